// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and the memory stage.
// Data has priority, but fetch wins after a run of data grants; hung accesses time out.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_stall,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            timeout_err
);

  localparam int BW = DW / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TmoLast =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT
  } state_t;

  state_t          state, stateNxt;
  logic            ownerD, ownerDNxt;
  logic [3:0]      starveCnt, starveNxt;
  logic [TW-1:0]   tmoCnt, tmoNxt;
  logic            mReqNxt, mWeNxt, errNxt;
  logic [AW-1:0]   mAddrNxt;
  logic [DW-1:0]   mWdataNxt;
  logic [BW-1:0]   mBeNxt;
  logic            grantD, tmoHit, rspDone, done;
  logic            iDone, dDone;
  logic [DW-1:0]   rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ownerD      <= 1'b0;
      starveCnt   <= '0;
      tmoCnt      <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_be        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= stateNxt;
      ownerD      <= ownerDNxt;
      starveCnt   <= starveNxt;
      tmoCnt      <= tmoNxt;
      m_req       <= mReqNxt;
      m_we        <= mWeNxt;
      m_addr      <= mAddrNxt;
      m_wdata     <= mWdataNxt;
      m_be        <= mBeNxt;
      timeout_err <= errNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    ownerDNxt = ownerD;
    starveNxt = starveCnt;
    tmoNxt    = '0;
    mReqNxt   = m_req;
    mWeNxt    = m_we;
    mAddrNxt  = m_addr;
    mWdataNxt = m_wdata;
    mBeNxt    = m_be;
    errNxt    = timeout_err;

    grantD  = d_req && !(i_req && starveCnt == StarveMax);
    tmoHit  = (TIMEOUT != 0) && (state != IDLE) && (tmoCnt == TmoLast);
    rspDone = (state == WAIT) && m_rvalid;
    done    = rspDone || tmoHit;

    unique case (state)
      IDLE: begin
        if (grantD) begin
          ownerDNxt = 1'b1;
          mReqNxt   = 1'b1;
          mWeNxt    = d_we;
          mAddrNxt  = d_addr;
          mWdataNxt = d_wdata;
          mBeNxt    = d_be;
          stateNxt  = ADDR;
          if (!i_req) starveNxt = '0;
          else if (starveCnt != StarveMax)
            starveNxt = starveCnt + 4'd1;
        end else if (i_req) begin
          ownerDNxt = 1'b0;
          mReqNxt   = 1'b1;
          mWeNxt    = 1'b0;
          mAddrNxt  = i_addr;
          mWdataNxt = '0;
          mBeNxt    = '1;
          stateNxt  = ADDR;
          starveNxt = '0;
        end
      end
      ADDR: begin
        tmoNxt = tmoCnt + 1'b1;
        if (m_gnt) begin
          mReqNxt  = 1'b0;
          stateNxt = WAIT;
        end
      end
      WAIT: begin
        tmoNxt = tmoCnt + 1'b1;
        if (rspDone) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase

    // a genuine response in the last allowed cycle beats the abort
    if (tmoHit && !rspDone) begin
      stateNxt = IDLE;
      mReqNxt  = 1'b0;
      errNxt   = 1'b1;
    end
    if (stateNxt == IDLE) tmoNxt = '0;
  end

  always_comb begin
    iDone   = done && !ownerD;
    dDone   = done && ownerD;
    rdata   = (rspDone && !m_we) ? m_rdata : '0;
    i_rdata = iDone ? rdata : '0;
    d_rdata = dDone ? rdata : '0;
    i_stall = i_req && !iDone;
    d_stall = d_req && !dDone;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, starvation,
// flush, timeout and async reset, each checked with immediate assertions.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        timeout_err;

  int nTests = 0;
  int nFail  = 0;

  mem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    #12;
    chk("rst_mreq", 32'(m_req), 0);
    chk("rst_mbe", 32'(m_be), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_istall", 32'(i_stall), 0);
    rst = 1'b0;

    // fetch only
    cyc(); i_req = 1; i_addr = 32'h100; #1;
    chk("f0_istall", 32'(i_stall), 1);
    chk("f0_mreq", 32'(m_req), 0);
    cyc(); m_gnt = 1; #1;
    chk("f1_mreq", 32'(m_req), 1);
    chk("f1_maddr", m_addr, 32'h100);
    chk("f1_mbe", 32'(m_be), 32'hF);
    chk("f1_mwe", 32'(m_we), 0);
    chk("f1_istall", 32'(i_stall), 1);
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; #1;
    chk("f2_istall", 32'(i_stall), 0);
    chk("f2_irdata", i_rdata, 32'hDEADBEEF);
    chk("f2_mreq", 32'(m_req), 0);
    cyc(); i_req = 0; m_rvalid = 0; #1;
    chk("f3_irdata", i_rdata, 0);

    // simultaneous: data store first, then fetch
    cyc();
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000;
    d_wdata = 32'h12345678; d_be = 4'h3; #1;
    chk("s0_dstall", 32'(d_stall), 1);
    chk("s0_istall", 32'(i_stall), 1);
    cyc(); m_gnt = 1; #1;
    chk("s1_mwe", 32'(m_we), 1);
    chk("s1_mbe", 32'(m_be), 32'h3);
    chk("s1_maddr", m_addr, 32'h2000);
    chk("s1_mwdata", m_wdata, 32'h12345678);
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hAAAA5555; #1;
    chk("s2_dstall", 32'(d_stall), 0);
    chk("s2_drdata", d_rdata, 0);
    chk("s2_istall", 32'(i_stall), 1);
    cyc(); d_req = 0; m_rvalid = 0; #1;
    chk("s3_mreq", 32'(m_req), 0);
    cyc(); m_gnt = 1; #1;
    chk("s4_maddr", m_addr, 32'h104);
    chk("s4_mbe", 32'(m_be), 32'hF);
    chk("s4_mwdata", m_wdata, 0);
    chk("s4_mwe", 32'(m_we), 0);
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFEF00D; #1;
    chk("s5_irdata", i_rdata, 32'hCAFEF00D);
    chk("s5_istall", 32'(i_stall), 0);
    cyc(); i_req = 0; m_rvalid = 0;

    // starvation: four data loads, then fetch
    cyc();
    i_req = 1; i_addr = 32'h108;
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
    for (int g = 0; g < 5; g++) begin
      cyc(); m_gnt = 1; #1;
      chk($sformatf("st%0d_maddr", g), m_addr,
          (g < 4) ? 32'h3000 : 32'h108);
      cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'(g + 1); #1;
      if (g < 4) begin
        chk($sformatf("st%0d_drdata", g), d_rdata, 32'(g + 1));
        chk($sformatf("st%0d_istall", g), 32'(i_stall), 1);
      end else begin
        chk("st4_irdata", i_rdata, 32'd5);
        chk("st4_dstall", 32'(d_stall), 1);
      end
      cyc(); m_rvalid = 0;
    end
    // counter cleared: data wins again
    cyc(); m_gnt = 1; #1;
    chk("st5_maddr", m_addr, 32'h3000);
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 0;
    cyc(); m_rvalid = 0; i_req = 0; d_req = 0;

    // flush: fetch withdraws in WAIT
    cyc(); i_req = 1; i_addr = 32'h200;
    cyc(); m_gnt = 1;
    cyc(); m_gnt = 0; i_req = 0; #1;
    chk("fl_wait_istall", 32'(i_stall), 0);
    chk("fl_wait_mreq", 32'(m_req), 0);
    cyc(); m_rvalid = 1; m_rdata = 32'h1111; #1;
    chk("fl_rv_istall", 32'(i_stall), 0);
    cyc(); m_rvalid = 0;
    d_req = 1; d_we = 0; d_addr = 32'h400; #1;
    chk("fl_n0_dstall", 32'(d_stall), 1);
    cyc(); m_gnt = 1; #1;
    chk("fl_n1_maddr", m_addr, 32'h400);
    chk("fl_n1_mreq", 32'(m_req), 1);
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h77; #1;
    chk("fl_n2_drdata", d_rdata, 32'h77);
    chk("fl_n2_dstall", 32'(d_stall), 0);
    cyc(); d_req = 0; m_rvalid = 0;

    // timeout: memory never grants
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h500;
    for (int c = 1; c <= 7; c++) begin
      cyc(); #1;
      chk($sformatf("to%0d_dstall", c), 32'(d_stall), 1);
      chk($sformatf("to%0d_mreq", c), 32'(m_req), 1);
    end
    cyc(); m_rdata = 32'hFFFFFFFF; #1;
    chk("to8_dstall", 32'(d_stall), 0);
    chk("to8_drdata", d_rdata, 0);
    chk("to8_err", 32'(timeout_err), 0);
    cyc(); d_req = 0; #1;
    chk("to9_err", 32'(timeout_err), 1);
    chk("to9_mreq", 32'(m_req), 0);
    cyc(); m_rvalid = 1; #1;
    chk("to10_drdata", d_rdata, 0);
    chk("to10_irdata", i_rdata, 0);
    cyc(); m_rvalid = 0; #1;
    chk("to11_err", 32'(timeout_err), 1);
    chk("to11_mreq", 32'(m_req), 0);

    // async reset while in WAIT
    cyc();
    i_req = 1; i_addr = 32'h600;
    d_req = 1; d_we = 1; d_addr = 32'h700; d_be = 4'h1;
    cyc(); m_gnt = 1;
    cyc(); m_gnt = 0; #1;
    chk("ar_wait_dstall", 32'(d_stall), 1);
    chk("ar_wait_maddr", m_addr, 32'h700);
    #1; rst = 1; #1;
    chk("ar_maddr", m_addr, 0);
    chk("ar_mbe", 32'(m_be), 0);
    chk("ar_err", 32'(timeout_err), 0);
    chk("ar_istall", 32'(i_stall), 1);
    chk("ar_dstall", 32'(d_stall), 1);
    i_req = 0; #1;
    chk("ar_istall0", 32'(i_stall), 0);
    d_req = 0; i_req = 1; i_addr = 32'h300; #1;
    rst = 0;
    cyc(); m_gnt = 1; #1;
    chk("ar_n1_maddr", m_addr, 32'h300);
    chk("ar_n1_mreq", 32'(m_req), 1);
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h5A5A0001; #1;
    chk("ar_n2_irdata", i_rdata, 32'h5A5A0001);
    cyc(); i_req = 0; m_rvalid = 0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
